// File: rtl/tx_whitening_bluetooth_ble.sv
// BLE TX data-whitening stage. Serial PDU+CRC bits from the CRC stage are XORed
// with the x^7+x^4+1 whitening LFSR, seeded from the RF channel index at frame
// start, and forwarded one registered cycle later to the modulator feed.
// Per-frame bit count and a length-overflow flag are reported alongside.
//
// Handshake: valid_in qualifies data_in/crc_flag_in each cycle; a contiguous run
// of valid_in=1 is one frame and the first cycle with valid_in=0 ends it. There
// is no ready: every valid_out bit must be consumed the cycle it is presented.
module tx_whitening_bluetooth_ble #(
  parameter int MAX_BITS = 2064,
  parameter int CNT_W    = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             data_in,
  input  logic             crc_flag_in,
  input  logic             whiten_en,
  input  logic [5:0]       chan_idx,
  output logic             data_out,
  output logic             valid_out,
  output logic             crc_flag_out,
  output logic             frame_done,
  output logic [CNT_W-1:0] bit_count,
  output logic             len_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    WHITEN = 1'b1
  } state_t;

  // One bit wider than the counter so the limit compare cannot wrap.
  localparam logic [CNT_W:0] MaxBitsW = (CNT_W+1)'(MAX_BITS);

  state_t           state_q, state_d;
  logic [6:0]       lfsr_q, lfsr_d;      // bit i holds LFSR position p_i
  logic             wen_q, wen_d;        // whiten_en latched at frame start
  logic             data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;
  logic             crc_flag_out_q, crc_flag_out_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             len_err_q, len_err_d;
  logic [6:0]       seed;

  // One shift of the whitening register; feedback from p6 into p0 and p4.
  function automatic logic [6:0] lfsr_step(input logic [6:0] p);
    logic [6:0] n;
    n[0] = p[6];
    n[1] = p[0];
    n[2] = p[1];
    n[3] = p[2];
    n[4] = p[3] ^ p[6];
    n[5] = p[4];
    n[6] = p[5];
    return n;
  endfunction

  // Seed: p0=1, p1..p6 = chan_idx[5]..chan_idx[0], so chan_idx[0] is the first whitening bit.
  always_comb begin
    seed = {chan_idx[0], chan_idx[1], chan_idx[2], chan_idx[3],
            chan_idx[4], chan_idx[5], 1'b1};
  end

  // Next-state, LFSR, counter and output computation for both frame states.
  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    wen_d          = wen_q;
    data_out_d     = 1'b0;
    valid_out_d    = 1'b0;
    crc_flag_out_d = 1'b0;
    frame_done_d   = 1'b0;
    bit_count_d    = bit_count_q;
    len_err_d      = len_err_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          data_out_d  = data_in ^ (whiten_en & seed[6]);
          valid_out_d = 1'b1;
          lfsr_d      = lfsr_step(seed);
          wen_d       = whiten_en;
          bit_count_d = CNT_W'(1);
          len_err_d   = 1'b0;
          state_d     = WHITEN;
        end
      end
      WHITEN: begin
        if (valid_in) begin
          data_out_d     = data_in ^ (wen_q & lfsr_q[6]);
          valid_out_d    = 1'b1;
          crc_flag_out_d = crc_flag_in;
          lfsr_d         = lfsr_step(lfsr_q);
          if (bit_count_q != {CNT_W{1'b1}}) begin
            bit_count_d = bit_count_q + CNT_W'(1);
          end
          // This bit would push the count past the legal frame length.
          if ({1'b0, bit_count_q} >= MaxBitsW) begin
            len_err_d = 1'b1;
          end
        end else begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; async active-low reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      lfsr_q         <= 7'h00;
      wen_q          <= 1'b0;
      data_out_q     <= 1'b0;
      valid_out_q    <= 1'b0;
      crc_flag_out_q <= 1'b0;
      frame_done_q   <= 1'b0;
      bit_count_q    <= '0;
      len_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      wen_q          <= wen_d;
      data_out_q     <= data_out_d;
      valid_out_q    <= valid_out_d;
      crc_flag_out_q <= crc_flag_out_d;
      frame_done_q   <= frame_done_d;
      bit_count_q    <= bit_count_d;
      len_err_q      <= len_err_d;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign crc_flag_out = crc_flag_out_q;
  assign frame_done   = frame_done_q;
  assign bit_count    = bit_count_q;
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_tx_whitening_bluetooth_ble.sv
// Bench for tx_whitening_bluetooth_ble: directed and random frames checked
// against a sequence model of the BLE whitening register. A second instance
// built with a small frame limit covers the length-overflow flag.
module tb_tx_whitening_bluetooth_ble;

  localparam int CNT_W   = 14;
  localparam int SAT     = (1 << CNT_W) - 1;
  localparam int MAX_DEF = 2064;
  localparam int MAX_SML = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             valid_in, data_in, crc_flag_in, whiten_en;
  logic [5:0]       chan_idx;
  logic             data_out, valid_out, crc_flag_out, frame_done, len_err;
  logic [CNT_W-1:0] bit_count;
  logic             s_data_out, s_valid_out, s_crc_flag_out, s_frame_done, s_len_err;
  logic [CNT_W-1:0] s_bit_count;

  tx_whitening_bluetooth_ble #(.MAX_BITS(MAX_DEF), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .crc_flag_in(crc_flag_in), .whiten_en(whiten_en), .chan_idx(chan_idx),
    .data_out(data_out), .valid_out(valid_out), .crc_flag_out(crc_flag_out),
    .frame_done(frame_done), .bit_count(bit_count), .len_err(len_err)
  );

  tx_whitening_bluetooth_ble #(.MAX_BITS(MAX_SML), .CNT_W(CNT_W)) dut_s (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .crc_flag_in(crc_flag_in), .whiten_en(whiten_en), .chan_idx(chan_idx),
    .data_out(s_data_out), .valid_out(s_valid_out), .crc_flag_out(s_crc_flag_out),
    .frame_done(s_frame_done), .bit_count(s_bit_count), .len_err(s_len_err)
  );

  // ---------------- scoreboard ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic        fbits[$];
  logic        fcrc[$];
  logic [0:0]  exp_q[$];
  logic [31:0] got_bits;
  logic        first_bit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference whitening sequence: seven-position register walked bit by bit.
  task automatic build_exp(input int n, input logic [5:0] ch, input logic wen);
    logic p[7];
    logic t6;
    p[0] = 1'b1;
    for (int i = 1; i < 7; i++) p[i] = ch[6-i];
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(fbits[k] ^ (wen & p[6]));
      t6 = p[6];
      for (int i = 6; i > 0; i--) p[i] = p[i-1];
      p[0] = t6;
      p[4] = p[4] ^ t6;
    end
  endtask

  // Random payload of n bits whose last ncrc bits are flagged as CRC.
  task automatic fill(input int n, input int ncrc);
    fbits.delete();
    fcrc.delete();
    for (int k = 0; k < n; k++) begin
      fbits.push_back(1'($urandom));
      fcrc.push_back(k >= n - ncrc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // ---------------- driver tasks ----------------
  // Starts a frame at the current time (just after a rising edge), checks every
  // output bit and the frame_done cycle, and returns just after that edge.
  task automatic drive_frame(input int n, input logic [5:0] ch, input logic wen,
                             input bit scramble);
    build_exp(n, ch, wen);
    chan_idx    = ch;
    whiten_en   = wen;
    valid_in    = 1'b1;
    data_in     = fbits[0];
    crc_flag_in = fcrc[0];
    got_bits    = '0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k < 32) got_bits[k] = data_out;
      chk("valid_out", {31'b0, valid_out}, 32'd1);
      chk("data_out", {31'b0, data_out}, {31'b0, exp_q[k]});
      chk("crc_flag_out", {31'b0, crc_flag_out}, {31'b0, fcrc[k]});
      chk("frame_done_low", {31'b0, frame_done}, 32'd0);
      chk("bit_count", {18'b0, bit_count}, 32'(sat(k + 1)));
      chk("len_err", {31'b0, len_err}, {31'b0, (k + 1) > MAX_DEF});
      chk("s_len_err", {31'b0, s_len_err}, {31'b0, (k + 1) > MAX_SML});
      chk("s_data_out", {31'b0, s_data_out}, {31'b0, exp_q[k]});
      if (k < n - 1) begin
        data_in     = fbits[k+1];
        crc_flag_in = fcrc[k+1];
        if (scramble) begin
          chan_idx  = 6'($urandom_range(0, 63));
          whiten_en = 1'($urandom);
        end
      end else begin
        valid_in    = 1'b0;
        data_in     = 1'($urandom);
        crc_flag_in = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("end_valid_out", {31'b0, valid_out}, 32'd0);
    chk("end_data_out", {31'b0, data_out}, 32'd0);
    chk("end_crc_flag_out", {31'b0, crc_flag_out}, 32'd0);
    chk("frame_done", {31'b0, frame_done}, 32'd1);
    chk("s_frame_done", {31'b0, s_frame_done}, 32'd1);
    chk("end_bit_count", {18'b0, bit_count}, 32'(sat(n)));
    chk("end_len_err", {31'b0, len_err}, {31'b0, n > MAX_DEF});
    chk("end_s_len_err", {31'b0, s_len_err}, {31'b0, n > MAX_SML});
  endtask

  task automatic idle_cycles(input int m);
    for (int i = 0; i < m; i++) begin
      data_in = 1'($urandom);
      @(posedge clk);
      #1;
      chk("idle_valid_out", {31'b0, valid_out}, 32'd0);
      chk("idle_frame_done", {31'b0, frame_done}, 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    valid_in = 1'b0; data_in = 1'b0; crc_flag_in = 1'b0;
    whiten_en = 1'b0; chan_idx = 6'd0;
    #12;
    chk("rst_data_out", {31'b0, data_out}, 32'd0);
    chk("rst_valid_out", {31'b0, valid_out}, 32'd0);
    chk("rst_crc_flag_out", {31'b0, crc_flag_out}, 32'd0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    chk("rst_bit_count", {18'b0, bit_count}, 32'd0);
    chk("rst_len_err", {31'b0, len_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // ch=37, whitening on, five zero bits -> 1,0,1,1,0
    fill(5, 0);
    for (int k = 0; k < 5; k++) fbits[k] = 1'b0;
    drive_frame(5, 6'd37, 1'b1, 1'b0);
    chk("ch37_zeros_seq", {27'b0, got_bits[4:0]}, 32'h0d);
    idle_cycles(2);

    // bypass then whitened with pattern 1,0,1,1,0
    fbits[0] = 1'b1; fbits[1] = 1'b0; fbits[2] = 1'b1; fbits[3] = 1'b1; fbits[4] = 1'b0;
    drive_frame(5, 6'd37, 1'b0, 1'b0);
    chk("bypass_seq", {27'b0, got_bits[4:0]}, 32'h0d);
    idle_cycles(1);
    drive_frame(5, 6'd37, 1'b1, 1'b0);
    chk("whiten_cancel_seq", {27'b0, got_bits[4:0]}, 32'h00);
    idle_cycles(1);

    // 24 PDU + 16 CRC bits, then a back-to-back frame on channel 0
    fill(40, 16);
    drive_frame(40, 6'd5, 1'b1, 1'b0);
    fill(12, 0);
    first_bit = fbits[0];
    drive_frame(12, 6'd0, 1'b1, 1'b0);
    chk("ch0_first_bit", {31'b0, got_bits[0]}, {31'b0, first_bit});
    idle_cycles(2);

    // mid-frame changes to chan_idx / whiten_en must be ignored
    fill(30, 0);
    drive_frame(30, 6'd21, 1'b1, 1'b1);
    idle_cycles(1);

    // overflow on the small-limit instance, then cleared by the next frame
    fill(10, 0);
    drive_frame(10, 6'd12, 1'b1, 1'b0);
    fill(3, 0);
    drive_frame(3, 6'd12, 1'b1, 1'b0);
    idle_cycles(1);

    // random frames, some chained, some with mid-frame input changes
    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(1, 60);
      fill(n, (n > 4) ? $urandom_range(0, n - 1) : 0);
      drive_frame(n, 6'($urandom_range(0, 63)), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(1);

    // reset for one clock in mid-frame: outputs clear at once, no frame_done
    fill(6, 0);
    chan_idx = 6'd9; whiten_en = 1'b1; valid_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_in = fbits[k];
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("midrst_valid_out", {31'b0, valid_out}, 32'd0);
    chk("midrst_data_out", {31'b0, data_out}, 32'd0);
    chk("midrst_bit_count", {18'b0, bit_count}, 32'd0);
    chk("midrst_frame_done", {31'b0, frame_done}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle_cycles(3);
    fill(5, 0);
    for (int k = 0; k < 5; k++) fbits[k] = 1'b0;
    drive_frame(5, 6'd37, 1'b1, 1'b0);
    chk("post_rst_seq", {27'b0, got_bits[4:0]}, 32'h0d);
    idle_cycles(1);

    // long frame: passes the default limit and saturates the bit counter
    fill(SAT + 20, 0);
    drive_frame(SAT + 20, 6'($urandom_range(0, 39)), 1'b1, 1'b0);
    idle_cycles(2);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
